// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
// master = controller side, slave = datapath side.
interface mips_multicycle_ctrl_if;
  logic [5:0] iOp;
  logic [5:0] iFunct;
  logic       iZero;
  logic       oIorD;
  logic       oMemWrite;
  logic       oIRWrite;
  logic       oRegDst;
  logic       oMemtoReg;
  logic       oRegWrite;
  logic       oALUSrcA;
  logic [1:0] oALUSrcB;
  logic [2:0] oALUControl;
  logic [1:0] oPCSrc;
  logic       oPCEn;
  logic [3:0] oState;

  modport master (
    input  iOp, iFunct, iZero,
    output oIorD, oMemWrite, oIRWrite, oRegDst, oMemtoReg, oRegWrite,
           oALUSrcA, oALUSrcB, oALUControl, oPCSrc, oPCEn, oState
  );

  modport slave (
    output iOp, iFunct, iZero,
    input  oIorD, oMemWrite, oIRWrite, oRegDst, oMemtoReg, oRegWrite,
           oALUSrcA, oALUSrcB, oALUControl, oPCSrc, oPCEn, oState
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore FSM sequencing a multicycle MIPS datapath with a shared, MEM_LAT-stalled memory.
// Define MCC_BNE_EN to add bne (opcode 000101) through the BRANCH state.
module mips_multicycle_ctrl #(
  parameter int MEM_LAT = 0
) (
  input logic iClk,
  input logic iReset,
  mips_multicycle_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  typedef struct packed {
    logic       iorD;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memtoReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSrc;
    logic       pcWrite;
    logic       branch;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MCC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif
  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT);

  logic [3:0] stateReg;
  logic [3:0] stateNext;
  logic [3:0] waitCntReg;
  logic [3:0] waitCntNext;
  logic       waitDone;
  logic       lastNext;
  ctrl_t      ctrlReg;
  ctrl_t      ctrlNext;
  logic       zeroTerm;
`ifdef MCC_BNE_EN
  logic       isBneReg;
`endif

  // FETCH loads IR and PC only on its final wait cycle.
  function automatic ctrl_t fetchCtrl(input logic last);
    ctrl_t c;
    c         = '0;
    c.aluSrcB = 2'b01;
    c.irWrite = last;
    c.pcWrite = last;
    return c;
  endfunction

  function automatic logic [2:0] aluControl(input logic [1:0] aluOp, input logic [5:0] funct);
    logic [2:0] ctl;
    ctl = 3'b010;
    if (aluOp == 2'b01) begin
      ctl = 3'b110;
    end else if (aluOp == 2'b10) begin
      case (funct)
        6'b100010: ctl = 3'b110;
        6'b100100: ctl = 3'b000;
        6'b100101: ctl = 3'b001;
        6'b101010: ctl = 3'b111;
        default:   ctl = 3'b010;
      endcase
    end
    return ctl;
  endfunction

  always_comb begin
    stateNext = FETCH;
    waitDone  = (waitCntReg == LAST_CNT);
    case (stateReg)
      FETCH:   stateNext = waitDone ? DECODE : FETCH;
      DECODE: begin
        case (bus.iOp)
          OP_LW, OP_SW: stateNext = MEMADR;
          OP_RTYPE:     stateNext = EXECUTE;
          OP_BEQ:       stateNext = BRANCH;
          OP_ADDI:      stateNext = ADDIEX;
          OP_J:         stateNext = JUMP;
`ifdef MCC_BNE_EN
          OP_BNE:       stateNext = BRANCH;
`endif
          default:      stateNext = FETCH;
        endcase
      end
      MEMADR:  stateNext = (bus.iOp == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   stateNext = waitDone ? MEMWB : MEMRD;
      MEMWR:   stateNext = waitDone ? FETCH : MEMWR;
      EXECUTE: stateNext = ALUWB;
      ADDIEX:  stateNext = ADDIWB;
      default: stateNext = FETCH;
    endcase
    // Only the wait states ever self-loop, so "same state" means "still waiting".
    waitCntNext = (stateNext == stateReg) ? waitCntReg + 4'd1 : 4'd0;
  end

  // Outputs are decoded from the upcoming state so they leave the register aligned with it.
  always_comb begin
    ctrlNext = '0;
    lastNext = (waitCntNext == LAST_CNT);
    case (stateNext)
      FETCH:  ctrlNext = fetchCtrl(lastNext);
      DECODE: ctrlNext.aluSrcB = 2'b11;
      MEMADR, ADDIEX: begin
        ctrlNext.aluSrcA = 1'b1;
        ctrlNext.aluSrcB = 2'b10;
      end
      MEMRD:  ctrlNext.iorD = 1'b1;
      MEMWB: begin
        ctrlNext.regWrite = 1'b1;
        ctrlNext.memtoReg = 1'b1;
      end
      MEMWR: begin
        ctrlNext.iorD     = 1'b1;
        ctrlNext.memWrite = lastNext;
      end
      EXECUTE: begin
        ctrlNext.aluSrcA = 1'b1;
        ctrlNext.aluOp   = 2'b10;
      end
      ALUWB: begin
        ctrlNext.regWrite = 1'b1;
        ctrlNext.regDst   = 1'b1;
      end
      ADDIWB: ctrlNext.regWrite = 1'b1;
      BRANCH: begin
        ctrlNext.aluSrcA = 1'b1;
        ctrlNext.aluOp   = 2'b01;
        ctrlNext.pcSrc   = 2'b01;
        ctrlNext.branch  = 1'b1;
      end
      JUMP: begin
        ctrlNext.pcSrc   = 2'b10;
        ctrlNext.pcWrite = 1'b1;
      end
      default: ctrlNext = '0;
    endcase
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      stateReg   <= FETCH;
      waitCntReg <= 4'd0;
      ctrlReg    <= fetchCtrl(LAST_CNT == 4'd0);
`ifdef MCC_BNE_EN
      isBneReg   <= 1'b0;
`endif
    end else begin
      stateReg   <= stateNext;
      waitCntReg <= waitCntNext;
      ctrlReg    <= ctrlNext;
`ifdef MCC_BNE_EN
      if (stateReg == DECODE) begin
        isBneReg <= (bus.iOp == OP_BNE);
      end
`endif
    end
  end

`ifdef MCC_BNE_EN
  assign zeroTerm = bus.iZero ^ isBneReg;
`else
  assign zeroTerm = bus.iZero;
`endif

  // Write enables are masked while reset is held so an aborted instruction commits nothing.
  assign bus.oIorD       = ctrlReg.iorD;
  assign bus.oMemWrite   = ctrlReg.memWrite & ~iReset;
  assign bus.oIRWrite    = ctrlReg.irWrite & ~iReset;
  assign bus.oRegDst     = ctrlReg.regDst;
  assign bus.oMemtoReg   = ctrlReg.memtoReg;
  assign bus.oRegWrite   = ctrlReg.regWrite & ~iReset;
  assign bus.oALUSrcA    = ctrlReg.aluSrcA;
  assign bus.oALUSrcB    = ctrlReg.aluSrcB;
  assign bus.oALUControl = aluControl(ctrlReg.aluOp, bus.iFunct);
  assign bus.oPCSrc      = ctrlReg.pcSrc;
  assign bus.oPCEn       = (ctrlReg.pcWrite | (ctrlReg.branch & zeroTerm)) & ~iReset;
  assign bus.oState      = stateReg;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench: two controllers (MEM_LAT 0 and 2) run random instruction streams
// against an instruction-level reference model of the per-cycle control outputs.
module tb_mips_multicycle_ctrl;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic clk = 1'b0;
  logic rst0 = 1'b0;
  logic rst2 = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [18:0] q0[$];
  logic [18:0] q2[$];
  logic [18:0] act0;
  logic [18:0] act2;

  always #5 clk = ~clk;

  mips_multicycle_ctrl_if bus0();
  mips_multicycle_ctrl_if bus2();

  mips_multicycle_ctrl #(.MEM_LAT(0)) dut0 (.iClk(clk), .iReset(rst0), .bus(bus0));
  mips_multicycle_ctrl #(.MEM_LAT(2)) dut2 (.iClk(clk), .iReset(rst2), .bus(bus2));

  assign act0 = {bus0.oState, bus0.oIorD, bus0.oMemWrite, bus0.oIRWrite, bus0.oRegDst,
                 bus0.oMemtoReg, bus0.oRegWrite, bus0.oALUSrcA, bus0.oALUSrcB,
                 bus0.oALUControl, bus0.oPCSrc, bus0.oPCEn};
  assign act2 = {bus2.oState, bus2.oIorD, bus2.oMemWrite, bus2.oIRWrite, bus2.oRegDst,
                 bus2.oMemtoReg, bus2.oRegWrite, bus2.oALUSrcA, bus2.oALUSrcB,
                 bus2.oALUControl, bus2.oPCSrc, bus2.oPCEn};

  task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected cycle vector: {state, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
  // ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn}
  function automatic logic [18:0] v(input logic [3:0] s, input logic iord, input logic mw,
                                    input logic irw, input logic rd, input logic mtr,
                                    input logic rw, input logic sa, input logic [1:0] sb,
                                    input logic [2:0] alu, input logic [1:0] ps, input logic pe);
    return {s, iord, mw, irw, rd, mtr, rw, sa, sb, alu, ps, pe};
  endfunction

  function automatic logic [2:0] functCtl(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic [5:0] pickOp();
    case ($urandom_range(0, 7))
      0: return OP_LW;
      1: return OP_SW;
      2: return OP_R;
      3: return OP_BEQ;
      4: return OP_ADDI;
      5: return OP_J;
      6: return OP_BNE;
      default: return 6'($urandom);
    endcase
  endfunction

  function automatic logic [5:0] pickFunct();
    case ($urandom_range(0, 5))
      0: return 6'b100000;
      1: return 6'b100010;
      2: return 6'b100100;
      3: return 6'b100101;
      4: return 6'b101010;
      default: return 6'($urandom);
    endcase
  endfunction

  // Builds the whole instruction's cycle list, queues the first 'keep' entries (all if
  // keep<0), drives the IR fields and waits exactly that many cycles.
  task automatic runInstr(input int d, input logic [5:0] op, input logic [5:0] funct,
                          input logic zero, input int keep);
    logic [18:0] seq[$];
    int lat;
    int n;
    lat = (d == 0) ? 0 : 2;
    for (int i = 0; i <= lat; i++)
      seq.push_back(v(4'd0, 0, 0, i == lat, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, i == lat));
    seq.push_back(v(4'd1, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0));
    if (op == OP_LW) begin
      seq.push_back(v(4'd2, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0));
      for (int i = 0; i <= lat; i++)
        seq.push_back(v(4'd3, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b00, 0));
      seq.push_back(v(4'd4, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b010, 2'b00, 0));
    end else if (op == OP_SW) begin
      seq.push_back(v(4'd2, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0));
      for (int i = 0; i <= lat; i++)
        seq.push_back(v(4'd5, 1, i == lat, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b00, 0));
    end else if (op == OP_R) begin
      seq.push_back(v(4'd6, 0, 0, 0, 0, 0, 0, 1, 2'b00, functCtl(funct), 2'b00, 0));
      seq.push_back(v(4'd7, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b010, 2'b00, 0));
    end else if (op == OP_BEQ) begin
      seq.push_back(v(4'd8, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, zero));
    end else if (op == OP_ADDI) begin
      seq.push_back(v(4'd9, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0));
      seq.push_back(v(4'd10, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b010, 2'b00, 0));
    end else if (op == OP_J) begin
      seq.push_back(v(4'd11, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b10, 1));
    end
`ifdef MCC_BNE_EN
    else if (op == OP_BNE) begin
      seq.push_back(v(4'd8, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, ~zero));
    end
`endif
    n = (keep >= 0 && keep < seq.size()) ? keep : seq.size();
    for (int i = 0; i < n; i++) begin
      if (d == 0) q0.push_back(seq[i]);
      else q2.push_back(seq[i]);
    end
    if (d == 0) begin
      bus0.iOp = op; bus0.iFunct = funct; bus0.iZero = zero;
    end else begin
      bus2.iOp = op; bus2.iFunct = funct; bus2.iZero = zero;
    end
    $display("dut%0d issue op=%b funct=%b zero=%b cycles=%0d", d, op, funct, zero, n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkInReset(input int d, input string tag);
    if (d == 0) begin
      check({tag, "_state0"}, 19'(bus0.oState), 19'd0);
      check({tag, "_we0"}, 19'({bus0.oIRWrite, bus0.oPCEn, bus0.oRegWrite, bus0.oMemWrite}), 19'd0);
    end else begin
      check({tag, "_state2"}, 19'(bus2.oState), 19'd0);
      check({tag, "_we2"}, 19'({bus2.oIRWrite, bus2.oPCEn, bus2.oRegWrite, bus2.oMemWrite}), 19'd0);
    end
  endtask

  // Reset pulse for one DUT, issued right after an active edge.
  task automatic abortReset(input int d);
    if (d == 0) rst0 = 1'b1;
    else rst2 = 1'b1;
    @(negedge clk);
    checkInReset(d, "abort");
    @(posedge clk);
    #1;
    if (d == 0) rst0 = 1'b0;
    else rst2 = 1'b0;
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) check("dut0_cycle", act0, q0.pop_front());
    if (q2.size() > 0) check("dut2_cycle", act2, q2.pop_front());
  end

  initial begin
    bus0.iOp = '0; bus0.iFunct = '0; bus0.iZero = 1'b0;
    bus2.iOp = '0; bus2.iFunct = '0; bus2.iZero = 1'b0;
    rst0 = 1'b1;
    rst2 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkInReset(0, "reset");
    checkInReset(2, "reset");
    @(posedge clk);
    #1;
    rst0 = 1'b0;
    rst2 = 1'b0;
    fork
      begin
        runInstr(0, OP_LW, 6'b000000, 1'b0, -1);
        runInstr(0, OP_R, 6'b100000, 1'b0, -1);
        runInstr(0, OP_R, 6'b100010, 1'b0, -1);
        runInstr(0, OP_BEQ, 6'b000000, 1'b1, -1);
        runInstr(0, OP_BEQ, 6'b000000, 1'b0, -1);
        runInstr(0, 6'b111111, 6'b000000, 1'b0, -1);
        runInstr(0, OP_BNE, 6'b000000, 1'b0, -1);
        force dut0.stateReg = 4'd13;
        @(negedge clk);
        release dut0.stateReg;
        @(posedge clk);
        #1;
        runInstr(0, OP_SW, 6'b000000, 1'b0, -1);
        runInstr(0, OP_ADDI, 6'b000000, 1'b0, -1);
        runInstr(0, OP_J, 6'b000000, 1'b1, -1);
        runInstr(0, OP_LW, 6'b000000, 1'b0, 3);
        abortReset(0);
        for (int i = 0; i < 40; i++)
          runInstr(0, pickOp(), pickFunct(), 1'($urandom_range(0, 1)), -1);
      end
      begin
        runInstr(2, OP_SW, 6'b000000, 1'b0, -1);
        runInstr(2, OP_LW, 6'b000000, 1'b0, -1);
        runInstr(2, OP_SW, 6'b000000, 1'b0, 6);
        abortReset(2);
        for (int i = 0; i < 30; i++)
          runInstr(2, pickOp(), pickFunct(), 1'($urandom_range(0, 1)), -1);
      end
    join
    check("q0_drain", 19'(q0.size()), 19'd0);
    check("q2_drain", 19'(q2.size()), 19'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore-style FSM that sequences the multicycle MIPS datapath: shared instruction/data memory, IR, A/B/ALUOut/Data registers.
- Replaces the combinational single-cycle controller; stalls on memory states for a configurable latency.
- Supports lw, sw, R-type (add/sub/and/or/slt), beq, addi and j.

Parameters:
- MEM_LAT, 0: extra wait cycles spent in each memory-access state (FETCH, MEMRD, MEMWR); legal range 0..15.

Ports:
- iClk  in  1  clock, rising edge
- iReset  in  1  asynchronous, active-high reset
- iOp  in  6  IR[31:26]
- iFunct  in  6  IR[5:0]
- iZero  in  1  ALU zero flag, current cycle
- oIorD  out  1  memory address select: 0=PC, 1=ALUOut
- oMemWrite  out  1  memory write enable
- oIRWrite  out  1  instruction register load
- oRegDst  out  1  register write address: 0=rt, 1=rd
- oMemtoReg  out  1  register write data: 0=ALUOut, 1=Data
- oRegWrite  out  1  register file write enable
- oALUSrcA  out  1  ALU A: 0=PC, 1=A register
- oALUSrcB  out  2  ALU B: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
- oALUControl  out  3  ALU function
- oPCSrc  out  2  next PC: 00=ALUResult, 01=ALUOut, 10=jump target
- oPCEn  out  1  PC load enable
- oState  out  4  current state encoding

Behaviour:
- Reset: async to FETCH (0), wait counter 0. While iReset=1, oIRWrite, oPCEn, oRegWrite and oMemWrite are forced 0.
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11
  - Codes 12..15 are illegal and go to FETCH on the next edge.
- Transitions:
  - FETCH -> DECODE
  - DECODE: lw/sw -> MEMADR; R-type (000000) -> EXECUTE; beq (000100) -> BRANCH; addi (001000) -> ADDIEX; j (000010) -> JUMP; any other opcode -> FETCH (executes as nop)
  - MEMADR: lw (100011) -> MEMRD; sw (101011) -> MEMWR
  - MEMRD -> MEMWB; EXECUTE -> ALUWB; ADDIEX -> ADDIWB
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP -> FETCH
- Wait counter: in FETCH, MEMRD and MEMWR the FSM holds for MEM_LAT+1 cycles. The counter clears on state entry and the state advances when counter==MEM_LAT.
  - oIRWrite and the PC write in FETCH pulse only on the last FETCH cycle.
  - oMemWrite pulses only on the last MEMWR cycle.
  - oIorD stays 1 for all cycles of MEMRD and MEMWR.
- ALUOp (internal): 00=add, 01=sub, 10=use funct.
- Funct decode: 100000 -> 010; 100010 -> 110; 100100 -> 000; 100101 -> 001; 101010 -> 111; any other funct -> 010.
- Non-default outputs per state; every unlisted output is 0, ALUSrcB=00, PCSrc=00:
  - FETCH: ALUSrcB=01, ALUOp=00, IRWrite and PCWrite on the last cycle
  - DECODE: ALUSrcB=11, ALUOp=00
  - MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00
  - MEMRD: IorD=1
  - MEMWB: RegWrite=1, MemtoReg=1
  - MEMWR: IorD=1, MemWrite on the last cycle
  - EXECUTE: ALUSrcA=1, ALUOp=10
  - ALUWB: RegWrite=1, RegDst=1
  - ADDIWB: RegWrite=1
  - BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1
  - JUMP: PCSrc=10, PCWrite=1
- oPCEn = PCWrite | (Branch & iZero). This is combinational from iZero in the same cycle.
- Instruction latency with MEM_LAT=0:
  - lw 5 cycles; sw, R-type and addi 4; beq and j 3.
  - Each memory state adds MEM_LAT cycles.
- Reset asserted mid-instruction aborts it: no register or memory write occurs after the reset edge.

Optional Feature:
- Macro MCC_BNE_EN.
- When defined: opcode 000101 (bne) goes DECODE -> BRANCH. In BRANCH, oPCEn = Branch & (iZero ^ isBne), where isBne is latched in DECODE.
- When undefined: 000101 is an unknown opcode and goes DECODE -> FETCH with no PC update in BRANCH.

Test Plan:
- Reset pulse mid-FETCH -> oState=0, all write enables 0 during reset; first oIRWrite=1, oPCEn=1 on the first cycle after release (MEM_LAT=0).
- lw (op 100011), MEM_LAT=0 -> states 0,1,2,3,4; oRegWrite=1 with oMemtoReg=1 in cycle 5; back to 0 in cycle 6.
- add (op 0, funct 100000) then sub (funct 100010) -> oALUControl=010 in EXECUTE, then 110; oRegDst=1 in ALUWB.
- beq with iZero=1, then iZero=0 -> oPCEn=1 with oPCSrc=01 in BRANCH for the first, oPCEn=0 for the second; 3 cycles each.
- sw, MEM_LAT=2 -> MEMWR lasts 3 cycles, oMemWrite=1 only in the third; whole instruction takes 8 cycles.
- Opcode 111111 and forced illegal state 13 -> the first returns DECODE -> FETCH with no writes; the second returns to FETCH next cycle. With MCC_BNE_EN, bne with iZero=0 -> oPCEn=1.
